// File: rtl/uart_rx_frame_ctrl.sv
// Hunts for SYNC_BYTE, buffers a length-prefixed payload, verifies an additive checksum, then drains it.
// Drain starts the cycle after the CHK byte; o_data/o_data_last hold while i_data_ready is low.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 4340
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ready,
    output logic       o_data_last,
    output logic [7:0] o_frame_len,
    output logic       o_busy,
    output logic       o_err_len,
    output logic       o_err_chk,
    output logic       o_err_timeout,
    output logic       o_err_overrun
);
    localparam int IW    = $clog2(MAX_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CLKS);
    localparam int DEPTH = 1 << IW;

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   rd_nxt;
    logic [7:0]      sum;
    logic [TW-1:0]   to_cnt;
    logic            in_frame;
    logic            expire;
    logic            xfer;

    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign expire   = in_frame && !i_rx_dv && (to_cnt == TW'(TIMEOUT_CLKS - 1));
    assign xfer     = o_data_valid && i_data_ready;
    assign rd_nxt   = rd_idx + 1'b1;
    assign o_busy   = (state != S_HUNT);

    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && i_rx_dv) begin
            mem[wr_idx] <= i_rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_HUNT;
            wr_idx        <= '0;
            rd_idx        <= '0;
            sum           <= '0;
            to_cnt        <= '0;
            o_data        <= '0;
            o_data_valid  <= 1'b0;
            o_data_last   <= 1'b0;
            o_frame_len   <= '0;
            o_err_len     <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;
        end else begin
            o_err_len     <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;

            if (i_rx_dv || !in_frame || expire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                S_HUNT: begin
                    if (i_rx_dv && i_rx_byte == SYNC_BYTE) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_rx_dv) begin
                        if (i_rx_byte != 8'd0 && i_rx_byte <= 8'(MAX_LEN)) begin
                            o_frame_len <= i_rx_byte;
                            sum         <= i_rx_byte;
                            wr_idx      <= '0;
                            state       <= S_PAYLOAD;
                        end else begin
                            o_err_len <= 1'b1;
                            state     <= S_HUNT;
                        end
                    end else if (expire) begin
                        o_err_timeout <= 1'b1;
                        state         <= S_HUNT;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_dv) begin
                        sum    <= sum + i_rx_byte;
                        wr_idx <= wr_idx + 1'b1;
                        if (8'(wr_idx) == o_frame_len - 8'd1) begin
                            state <= S_CHK;
                        end
                    end else if (expire) begin
                        o_err_timeout <= 1'b1;
                        state         <= S_HUNT;
                    end
                end
                S_CHK: begin
                    if (i_rx_dv) begin
                        if (i_rx_byte == sum) begin
                            state        <= S_DRAIN;
                            rd_idx       <= '0;
                            o_data       <= mem[IW'(0)];
                            o_data_valid <= 1'b1;
                            o_data_last  <= (o_frame_len == 8'd1);
                        end else begin
                            o_err_chk <= 1'b1;
                            state     <= S_HUNT;
                        end
                    end else if (expire) begin
                        o_err_timeout <= 1'b1;
                        state         <= S_HUNT;
                    end
                end
                S_DRAIN: begin
                    if (i_rx_dv) begin
                        o_err_overrun <= 1'b1;
                    end
                    if (xfer) begin
                        if (o_data_last) begin
                            state        <= S_HUNT;
                            o_data       <= '0;
                            o_data_valid <= 1'b0;
                            o_data_last  <= 1'b0;
                        end else begin
                            rd_idx      <= rd_nxt;
                            o_data      <= mem[rd_nxt];
                            o_data_last <= (8'(rd_nxt) == o_frame_len - 8'd1);
                        end
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed scenarios for uart_rx_frame_ctrl; bytes and ready are driven and outputs sampled on the falling edge.
module tb_uart_rx_frame_ctrl;
    localparam int TO = 4340;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx_dv = 1'b0;
    logic [7:0] i_rx_byte = 8'h00;
    logic       i_data_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_data_last;
    logic [7:0] o_frame_len;
    logic       o_busy;
    logic       o_err_len;
    logic       o_err_chk;
    logic       o_err_timeout;
    logic       o_err_overrun;

    int errors = 0;
    int checks = 0;
    int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0, n_vld = 0, n_multi = 0, n_bad_last = 0;
    int b_len, b_chk, b_to, b_ovr, b_vld;
    int hold_bad;
    logic [7:0] tx[$];
    logic [7:0] got[$];
    logic       got_last[$];

    uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
        .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .o_data_last(o_data_last), .o_frame_len(o_frame_len), .o_busy(o_busy),
        .o_err_len(o_err_len), .o_err_chk(o_err_chk), .o_err_timeout(o_err_timeout),
        .o_err_overrun(o_err_overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled just after the falling edge to stay clear of the stimulus process.
    always @(negedge clk) begin
        #2;
        if (o_err_len)     n_len++;
        if (o_err_chk)     n_chk++;
        if (o_err_timeout) n_to++;
        if (o_err_overrun) n_ovr++;
        if (o_data_valid)  n_vld++;
        if ($countones({o_err_len, o_err_chk, o_err_timeout, o_err_overrun}) > 1) n_multi++;
        if (o_data_last && !o_data_valid) n_bad_last++;
    end

    task automatic snap();
        b_len = n_len; b_chk = n_chk; b_to = n_to; b_ovr = n_ovr; b_vld = n_vld;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_dv = 1'b1;
        i_rx_byte = b;
        @(negedge clk);
        i_rx_dv = 1'b0;
        i_rx_byte = 8'h00;
    endtask

    task automatic send_tx();
        foreach (tx[i]) send(tx[i]);
    endtask

    task automatic drain(input logic [15:0] pat, input int maxcyc);
        logic [7:0] pd;
        logic       pstall;
        got.delete();
        got_last.delete();
        hold_bad = 0;
        pstall = 1'b0;
        pd = 8'h00;
        for (int c = 0; c < maxcyc; c++) begin
            i_data_ready = (c < 16) ? pat[c] : 1'b1;
            if (pstall && o_data !== pd) hold_bad++;
            if (o_data_valid && i_data_ready) begin
                got.push_back(o_data);
                got_last.push_back(o_data_last);
            end
            pstall = o_data_valid && !i_data_ready;
            pd = o_data;
            @(negedge clk);
        end
        i_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({o_data, o_data_valid, o_data_last, o_frame_len, o_err_len, o_err_chk, o_err_timeout, o_err_overrun} !== 22'd0)
            begin errors++; $display("FAIL reset_outputs: got data=%h vld=%b last=%b len=%h errs=%b%b%b%b, want all 0", o_data, o_data_valid, o_data_last, o_frame_len, o_err_len, o_err_chk, o_err_timeout, o_err_overrun); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        snap();
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_tx();
        checks++; if (o_data_valid !== 1'b1) begin errors++; $display("FAIL good_first_valid: got %b want 1", o_data_valid); end
        checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL good_first_data: got %h want 11", o_data); end
        checks++; if (o_frame_len !== 8'd3) begin errors++; $display("FAIL good_frame_len: got %0d want 3", o_frame_len); end
        drain(16'hFFFF, 3);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL good_xfer_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_d[i] || got_last[i] !== (i == 2))
                begin errors++; $display("FAIL good_byte%0d: got %h last=%b want %h last=%b", i, got[i], got_last[i], exp_d[i], i == 2); end
        end
        checks++; if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL good_end: got vld=%b busy=%b want 0 0", o_data_valid, o_busy); end
        @(negedge clk);
        checks++; if (n_len + n_chk + n_to + n_ovr !== b_len + b_chk + b_to + b_ovr) begin errors++; $display("FAIL good_no_errors: got %0d new pulses want 0", n_len + n_chk + n_to + n_ovr - b_len - b_chk - b_to - b_ovr); end
    endtask

    task automatic test_stall();
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_tx();
        drain(16'hFFF9, 10);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL stall_xfer_count: got %0d want 3", got.size()); end
        checks++; if (got.size() == 3 && {got[0], got[1], got[2]} !== 24'h112233) begin errors++; $display("FAIL stall_order: got %h %h %h want 11 22 33", got[0], got[1], got[2]); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes while stalled want 0", hold_bad); end
    endtask

    task automatic test_bad_chk();
        snap();
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send_tx();
        checks++; if (o_err_chk !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL chk_pulse: got err=%b busy=%b want 1 0", o_err_chk, o_busy); end
        repeat (3) @(negedge clk);
        checks++; if (n_chk - b_chk !== 1) begin errors++; $display("FAIL chk_pulse_count: got %0d want 1", n_chk - b_chk); end
        checks++; if (n_vld !== b_vld) begin errors++; $display("FAIL chk_no_valid: got %0d valid cycles want 0", n_vld - b_vld); end
        tx = '{8'hA5, 8'h02, 8'h40, 8'h01, 8'h43};
        send_tx();
        drain(16'hFFFF, 2);
        checks++; if (got.size() !== 2 || got[0] !== 8'h40 || got[1] !== 8'h01) begin errors++; $display("FAIL chk_recover: got %0d bytes want 40 01", got.size()); end
    endtask

    task automatic test_len_err();
        snap();
        tx = '{8'h00, 8'hFF, 8'hA5, 8'h00};
        send_tx();
        checks++; if (o_err_len !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL len_zero: got err=%b busy=%b want 1 0", o_err_len, o_busy); end
        tx = '{8'hA5, 8'h11};
        send_tx();
        checks++; if (o_err_len !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL len_17: got err=%b busy=%b want 1 0", o_err_len, o_busy); end
        repeat (2) @(negedge clk);
        checks++; if (n_len - b_len !== 2) begin errors++; $display("FAIL len_pulse_count: got %0d want 2", n_len - b_len); end
    endtask

    task automatic test_max_len();
        tx = '{8'hA5, 8'h10};
        for (int i = 1; i <= 16; i++) tx.push_back(8'(i));
        tx.push_back(8'h98);
        send_tx();
        checks++; if (o_frame_len !== 8'd16 || o_data_valid !== 1'b1) begin errors++; $display("FAIL max_accept: got len=%0d vld=%b want 16 1", o_frame_len, o_data_valid); end
        drain(16'hFFFF, 16);
        checks++; if (got.size() !== 16) begin errors++; $display("FAIL max_count: got %0d want 16", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i + 1) || got_last[i] !== (i == 15))
                begin errors++; $display("FAIL max_byte%0d: got %h last=%b want %h last=%b", i, got[i], got_last[i], 8'(i + 1), i == 15); end
        end
    endtask

    task automatic test_back_to_back();
        tx = '{8'hA5, 8'h01, 8'hA5, 8'hA6};
        send_tx();
        checks++; if (o_data !== 8'hA5 || o_data_last !== 1'b1) begin errors++; $display("FAIL b2b_sync_as_data: got %h last=%b want a5 1", o_data, o_data_last); end
        drain(16'hFFFF, 1);
        checks++; if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got vld=%b busy=%b want 0 0", o_data_valid, o_busy); end
        tx = '{8'hA5, 8'h01, 8'h7F, 8'h80};
        send_tx();
        checks++; if (o_data_valid !== 1'b1 || o_data !== 8'h7F || o_data_last !== 1'b1) begin errors++; $display("FAIL b2b_second: got vld=%b %h last=%b want 1 7f 1", o_data_valid, o_data, o_data_last); end
        drain(16'hFFFF, 1);
    endtask

    task automatic test_timeout();
        snap();
        tx = '{8'hA5, 8'h02, 8'h11};
        send_tx();
        repeat (TO - 1) @(negedge clk);
        checks++; if (o_err_timeout !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL to_early: got err=%b busy=%b want 0 1", o_err_timeout, o_busy); end
        @(negedge clk);
        checks++; if (o_err_timeout !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL to_pulse: got err=%b busy=%b want 1 0", o_err_timeout, o_busy); end
        send_tx();
        repeat (TO - 1) @(negedge clk);
        send(8'h22);
        checks++; if (o_err_timeout !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL to_expiry_byte: got err=%b busy=%b want 0 1", o_err_timeout, o_busy); end
        send(8'h35);
        drain(16'hFFFF, 2);
        checks++; if (got.size() !== 2 || got[0] !== 8'h11 || got[1] !== 8'h22) begin errors++; $display("FAIL to_expiry_frame: got %0d bytes want 11 22", got.size()); end
        checks++; if (n_to - b_to !== 1) begin errors++; $display("FAIL to_pulse_count: got %0d want 1", n_to - b_to); end
    endtask

    task automatic test_overrun();
        snap();
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_tx();
        @(negedge clk);
        send(8'hA5);
        checks++; if (o_err_overrun !== 1'b1 || o_data_valid !== 1'b1 || o_data !== 8'h11) begin errors++; $display("FAIL ovr_pulse: got err=%b vld=%b %h want 1 1 11", o_err_overrun, o_data_valid, o_data); end
        drain(16'hFFFF, 3);
        checks++; if (got.size() !== 3 || {got[0], got[1], got[2]} !== 24'h112233) begin errors++; $display("FAIL ovr_payload: got %0d bytes want 11 22 33", got.size()); end
        checks++; if (n_ovr - b_ovr !== 1) begin errors++; $display("FAIL ovr_pulse_count: got %0d want 1", n_ovr - b_ovr); end
    endtask

    task automatic test_reset_mid();
        snap();
        tx = '{8'hA5, 8'h03, 8'h11};
        send_tx();
        rst_n = 1'b0;
        #1;
        checks++; if ({o_busy, o_data_valid, o_data_last, o_data, o_frame_len} !== 19'd0) begin errors++; $display("FAIL rst_mid_outputs: got busy=%b vld=%b len=%h want 0", o_busy, o_data_valid, o_frame_len); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (n_len + n_chk + n_to + n_ovr !== b_len + b_chk + b_to + b_ovr) begin errors++; $display("FAIL rst_mid_no_err: got new error pulses"); end
        tx = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_tx();
        drain(16'hFFFF, 1);
        checks++; if (got.size() !== 1 || got[0] !== 8'h5A) begin errors++; $display("FAIL rst_mid_recover: got %0d bytes want 5a", got.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_stall();
        test_bad_chk();
        test_len_err();
        test_max_len();
        test_back_to_back();
        test_timeout();
        test_overrun();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL one_error_per_cycle: got %0d cycles with several", n_multi); end
        checks++; if (n_bad_last !== 0) begin errors++; $display("FAIL last_without_valid: got %0d cycles want 0", n_bad_last); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
